// File: rtl/i2s_apb_feeder.sv
`default_nettype none
// ============================================================================
// Module      : i2s_apb_feeder
// Description : APB master sequencer that streams stereo sample pairs into
//               an I2S transmitter's APB register file. Each pair is preceded
//               by a status poll; full FIFOs are re-polled after a gap. The
//               first PREFILL pairs are written before CR.I2S_ENABLE is set,
//               and the same prefill is repeated after a transmitter underrun.
// Ports       : i_clk, i_rst_n    - clock, asynchronous active-low reset
//               i_enable          - level, run (1) or drain and stop (0)
//               i_clear           - pulse, clears sticky o_underrun / o_err
//               s_valid/s_ready   - sample-pair stream handshake
//               s_left, s_right   - sample pair payload
//               m_p*              - APB master port to the I2S block
//               o_running         - local copy of CR.I2S_ENABLE
//               o_underrun, o_err - sticky status flags
//               o_pair_cnt        - number of pairs written (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_apb_feeder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          PREFILL   = 2,
  parameter int          POLL_GAP  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_clear,
  input  logic        s_valid,
  input  logic [31:0] s_left,
  input  logic [31:0] s_right,
  output logic        s_ready,
  output logic [31:0] m_paddr,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [31:0] m_pwdata,
  input  logic [31:0] m_prdata,
  input  logic        m_pready,
  input  logic        m_pslverr,
  output logic        o_running,
  output logic        o_underrun,
  output logic        o_err,
  output logic [15:0] o_pair_cnt
);

  localparam int c_PF_W  = $clog2(PREFILL + 1);
  localparam int c_GAP_W = $clog2(POLL_GAP + 1);

  localparam logic [c_PF_W-1:0]  c_PREFILL  = c_PF_W'(PREFILL);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(POLL_GAP - 1);

  localparam logic [31:0] c_ADDR_CR  = BASE_ADDR + 32'h0000_0000;
  localparam logic [31:0] c_ADDR_SR  = BASE_ADDR + 32'h0000_0004;
  localparam logic [31:0] c_ADDR_TXL = BASE_ADDR + 32'h0000_0008;
  localparam logic [31:0] c_ADDR_TXR = BASE_ADDR + 32'h0000_000C;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_POLL_S = 4'd2,
    S_POLL_A = 4'd3,
    S_GAP    = 4'd4,
    S_WRL_S  = 4'd5,
    S_WRL_A  = 4'd6,
    S_WRR_S  = 4'd7,
    S_WRR_A  = 4'd8,
    S_CR_S   = 4'd9,
    S_CR_A   = 4'd10
  } state_t;

  state_t              r_state;
  logic                r_s_ready;
  logic [31:0]         r_paddr;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [31:0]         r_pwdata;
  logic                r_running;
  logic                r_underrun;
  logic                r_err;
  logic [15:0]         r_pair_cnt;
  logic [31:0]         r_hold_l;
  logic [31:0]         r_hold_r;
  logic [c_PF_W-1:0]   r_prefill;
  logic [c_GAP_W-1:0]  r_gap_cnt;

  logic                w_ack;
  logic                w_set_err;
  logic                w_set_underrun;
  logic                w_full;
  logic [c_PF_W-1:0]   w_pf_next;
  logic                w_unused;

  // An access completes on the ACCESS cycle where the slave is ready.
  assign w_ack          = r_psel & r_penable & m_pready;
  assign w_set_err      = w_ack & m_pslverr;
  // The transmitter drops its own enable on underrun; tx_done while we
  // believe it is running is how that is observed.
  assign w_set_underrun = (r_state == S_POLL_A) & m_pready & r_running & m_prdata[4];
  assign w_full         = m_prdata[1] | m_prdata[3];
  assign w_pf_next      = (r_prefill == c_PREFILL) ? r_prefill : r_prefill + 1'b1;
  assign w_unused       = ^{m_prdata[31:5], m_prdata[2], m_prdata[0]};

  assign s_ready    = r_s_ready;
  assign m_paddr    = r_paddr;
  assign m_psel     = r_psel;
  assign m_penable  = r_penable;
  assign m_pwrite   = r_pwrite;
  assign m_pwdata   = r_pwdata;
  assign o_running  = r_running;
  assign o_underrun = r_underrun;
  assign o_err      = r_err;
  assign o_pair_cnt = r_pair_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_s_ready  <= 1'b0;
      r_paddr    <= 32'h0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_pwdata   <= 32'h0;
      r_running  <= 1'b0;
      r_underrun <= 1'b0;
      r_err      <= 1'b0;
      r_pair_cnt <= 16'h0;
      r_hold_l   <= 32'h0;
      r_hold_r   <= 32'h0;
      r_prefill  <= '0;
      r_gap_cnt  <= '0;
    end else begin
      // Sticky flags: a new set event takes priority over a clear.
      if (w_set_err) begin
        r_err <= 1'b1;
      end else if (i_clear) begin
        r_err <= 1'b0;
      end
      if (w_set_underrun) begin
        r_underrun <= 1'b1;
      end else if (i_clear) begin
        r_underrun <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_enable) begin
            r_state   <= S_FETCH;
            r_s_ready <= 1'b1;
          end
        end

        S_FETCH: begin
          if (s_valid) begin
            r_hold_l  <= s_left;
            r_hold_r  <= s_right;
            r_s_ready <= 1'b0;
            r_state   <= S_POLL_S;
            r_psel    <= 1'b1;
            r_paddr   <= c_ADDR_SR;
            r_pwrite  <= 1'b0;
            r_pwdata  <= 32'h0;
          end else if (!i_enable) begin
            r_s_ready <= 1'b0;
            if (r_running) begin
              r_state  <= S_CR_S;
              r_psel   <= 1'b1;
              r_paddr  <= c_ADDR_CR;
              r_pwrite <= 1'b1;
              r_pwdata <= 32'h0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        S_POLL_S: begin
          r_penable <= 1'b1;
          r_state   <= S_POLL_A;
        end

        S_POLL_A: begin
          if (m_pready) begin
            r_penable <= 1'b0;
            if (w_set_underrun) begin
              r_running <= 1'b0;
              r_prefill <= '0;
            end
            if (w_full) begin
              r_psel    <= 1'b0;
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end else begin
              // Back-to-back transfer: psel stays high into the TXL SETUP.
              r_state  <= S_WRL_S;
              r_paddr  <= c_ADDR_TXL;
              r_pwrite <= 1'b1;
              r_pwdata <= r_hold_l;
            end
          end
        end

        S_GAP: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            r_state  <= S_POLL_S;
            r_psel   <= 1'b1;
            r_paddr  <= c_ADDR_SR;
            r_pwrite <= 1'b0;
            r_pwdata <= 32'h0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        S_WRL_S: begin
          r_penable <= 1'b1;
          r_state   <= S_WRL_A;
        end

        S_WRL_A: begin
          // The pair is never split: TXR always follows TXL.
          if (m_pready) begin
            r_penable <= 1'b0;
            r_state   <= S_WRR_S;
            r_paddr   <= c_ADDR_TXR;
            r_pwdata  <= r_hold_r;
          end
        end

        S_WRR_S: begin
          r_penable <= 1'b1;
          r_state   <= S_WRR_A;
        end

        S_WRR_A: begin
          if (m_pready) begin
            r_penable  <= 1'b0;
            r_pair_cnt <= r_pair_cnt + 16'd1;
            r_prefill  <= w_pf_next;
            if (!r_running && (w_pf_next == c_PREFILL) && i_enable) begin
              r_state  <= S_CR_S;
              r_paddr  <= c_ADDR_CR;
              r_pwrite <= 1'b1;
              r_pwdata <= 32'h1;
            end else begin
              r_psel    <= 1'b0;
              r_state   <= S_FETCH;
              r_s_ready <= 1'b1;
            end
          end
        end

        S_CR_S: begin
          r_penable <= 1'b1;
          r_state   <= S_CR_A;
        end

        S_CR_A: begin
          if (m_pready) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_running <= r_pwdata[0];
            if (r_pwdata[0]) begin
              r_state   <= S_FETCH;
              r_s_ready <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_apb_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_apb_feeder
// Description : Self-checking bench for i2s_apb_feeder. An APB slave model
//               answers status polls (scriptable SR values), can stall the
//               TXL write and flag pslverr on the TXR write; a monitor logs
//               every completed transfer for comparison against expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2s_apb_feeder;

  localparam logic [31:0] c_BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_clear = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_left = 32'h0;
  logic [31:0] s_right = 32'h0;
  logic        s_ready;
  logic [31:0] m_paddr;
  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [31:0] m_pwdata;
  logic [31:0] m_prdata;
  logic        m_pready;
  logic        m_pslverr;
  logic        o_running;
  logic        o_underrun;
  logic        o_err;
  logic [15:0] o_pair_cnt;

  i2s_apb_feeder #(
    .BASE_ADDR (c_BASE),
    .PREFILL   (2),
    .POLL_GAP  (4)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_enable   (i_enable),
    .i_clear    (i_clear),
    .s_valid    (s_valid),
    .s_left     (s_left),
    .s_right    (s_right),
    .s_ready    (s_ready),
    .m_paddr    (m_paddr),
    .m_psel     (m_psel),
    .m_penable  (m_penable),
    .m_pwrite   (m_pwrite),
    .m_pwdata   (m_pwdata),
    .m_prdata   (m_prdata),
    .m_pready   (m_pready),
    .m_pslverr  (m_pslverr),
    .o_running  (o_running),
    .o_underrun (o_underrun),
    .o_err      (o_err),
    .o_pair_cnt (o_pair_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- APB slave model and transfer monitor -------------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } tx_t;

  tx_t         log_q[$];
  int          cyc_cnt = 0;
  int          sr_done = 0;     // special SR answers already consumed
  int          sr_target = 0;   // special SR answers requested so far
  logic [31:0] sr_special = 32'h0;
  logic        hold_txl = 1'b0;
  logic        err_txr = 1'b0;

  assign m_prdata  = (sr_done < sr_target) ? sr_special : 32'h0;
  assign m_pready  = !(hold_txl && m_pwrite && (m_paddr == c_BASE + 32'h8));
  assign m_pslverr = err_txr && m_pwrite && m_psel && m_penable && (m_paddr == c_BASE + 32'hC);

  always @(posedge clk) begin
    cyc_cnt++;
    if (rst_n && m_psel && m_penable && m_pready) begin
      log_q.push_back('{m_pwrite, m_paddr, m_pwrite ? m_pwdata : m_prdata, cyc_cnt});
      if (!m_pwrite && (m_paddr == c_BASE + 32'h4) && (sr_done < sr_target))
        sr_done <= sr_done + 1;
    end
  end

  // ---------------- checking helpers ---------------------------------------
  int   n_tests = 0;
  int   n_fail = 0;
  int   base = 0;
  logic saw_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_tx(input string nm, input int idx, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data);
    if (base + idx >= log_q.size()) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: transfer %0d missing (only %0d logged)", nm, idx, log_q.size() - base);
    end else begin
      chk({nm, ".wr"}, 32'(log_q[base+idx].wr), 32'(wr));
      chk({nm, ".addr"}, log_q[base+idx].addr, addr);
      if (wr) chk({nm, ".data"}, log_q[base+idx].data, data);
    end
  endtask

  task automatic wait_log(input string nm, input int n, input int budget);
    int k = 0;
    while ((log_q.size() < base + n) && (k < budget)) begin
      @(negedge clk);
      saw_ready = saw_ready | s_ready;
      k++;
    end
    if (log_q.size() < base + n) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, got %0d transfers expected %0d", nm, log_q.size() - base, n);
    end
  endtask

  task automatic wait_access(input string nm, input logic [31:0] addr);
    int k = 0;
    while (!(m_psel && m_penable && (m_paddr == addr)) && (k < 100)) begin
      @(negedge clk);
      k++;
    end
    if (!(m_psel && m_penable && (m_paddr == addr))) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout waiting for access to 0x%08h", nm, addr);
    end
  endtask

  task automatic send_pair(input logic [31:0] l, input logic [31:0] r);
    int k = 0;
    while (!s_ready && (k < 200)) begin
      @(negedge clk);
      k++;
    end
    if (!s_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_pair: s_ready never rose, got 0 expected 1");
    end else begin
      s_valid = 1'b1;
      s_left  = l;
      s_right = r;
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- vector table -------------------------------------------
  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic        cr;       // CR=1 write expected to follow this pair
    logic [31:0] exp_run;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vt[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'h1111_1111, 32'h2222_2222, 1'b0, 32'd0, 32'd1};
    vt[1] = '{32'h3333_3333, 32'h4444_4444, 1'b1, 32'd1, 32'd2};
    vt[2] = '{32'h5555_5555, 32'h6666_6666, 1'b0, 32'd1, 32'd3};
    vt[3] = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'd1, 32'd4};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("reset.apb", {30'h0, m_psel, m_penable}, 32'h0);
    chk("reset.paddr", m_paddr, 32'h0);
    chk("reset.pwdata", m_pwdata, 32'h0);
    chk("reset.flags", {27'h0, s_ready, m_pwrite, o_running, o_underrun, o_err}, 32'h0);
    chk("reset.cnt", 32'(o_pair_cnt), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    i_enable = 1'b1;

    // ---- table: plain pairs, SR=0, prefill then CR enable ----
    for (int i = 0; i < 4; i++) begin
      base = log_q.size();
      send_pair(vt[i].l, vt[i].r);
      wait_log($sformatf("v%0d.log", i), vt[i].cr ? 4 : 3, 100);
      @(negedge clk);
      chk_tx($sformatf("v%0d.rd", i), 0, 1'b0, c_BASE + 32'h4, 32'h0);
      chk_tx($sformatf("v%0d.txl", i), 1, 1'b1, c_BASE + 32'h8, vt[i].l);
      chk_tx($sformatf("v%0d.txr", i), 2, 1'b1, c_BASE + 32'hC, vt[i].r);
      if (vt[i].cr) chk_tx($sformatf("v%0d.cr", i), 3, 1'b1, c_BASE, 32'h1);
      chk($sformatf("v%0d.running", i), 32'(o_running), vt[i].exp_run);
      chk($sformatf("v%0d.cnt", i), 32'(o_pair_cnt), vt[i].exp_cnt);
    end

    // ---- FIFOs full for 3 polls, gaps of POLL_GAP between polls ----
    base = log_q.size();
    sr_special = 32'h0000_000A;
    sr_target  = sr_done + 3;
    send_pair(32'hA1A1_A1A1, 32'hA2A2_A2A2);
    saw_ready = 1'b0;
    wait_log("full.log", 5, 200);
    chk("full.s_ready_low", 32'(saw_ready), 32'h0);
    wait_log("full.log2", 6, 50);
    @(negedge clk);
    for (int j = 0; j < 4; j++) chk_tx($sformatf("full.rd%0d", j), j, 1'b0, c_BASE + 32'h4, 32'h0);
    chk_tx("full.txl", 4, 1'b1, c_BASE + 32'h8, 32'hA1A1_A1A1);
    chk_tx("full.txr", 5, 1'b1, c_BASE + 32'hC, 32'hA2A2_A2A2);
    if (log_q.size() >= base + 6) begin
      for (int j = 1; j < 4; j++)
        chk($sformatf("full.gap%0d", j), 32'(log_q[base+j].cyc - log_q[base+j-1].cyc), 32'd6);
    end
    chk("full.cnt", 32'(o_pair_cnt), 32'd5);

    // ---- pready low 3 cycles on TXL ----
    base = log_q.size();
    hold_txl = 1'b1;
    send_pair(32'hB1B1_B1B1, 32'hB2B2_B2B2);
    wait_access("stall.wait", c_BASE + 32'h8);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall.sel%0d", k), {30'h0, m_psel, m_penable}, 32'h3);
      chk($sformatf("stall.addr%0d", k), m_paddr, c_BASE + 32'h8);
      chk($sformatf("stall.data%0d", k), m_pwdata, 32'hB1B1_B1B1);
      chk($sformatf("stall.nlog%0d", k), 32'(log_q.size() - base), 32'd1);
      if (k == 3) hold_txl = 1'b0;
      @(negedge clk);
    end
    wait_log("stall.log", 3, 50);
    @(negedge clk);
    chk_tx("stall.txl", 1, 1'b1, c_BASE + 32'h8, 32'hB1B1_B1B1);
    chk_tx("stall.txr", 2, 1'b1, c_BASE + 32'hC, 32'hB2B2_B2B2);
    if (log_q.size() >= base + 3) begin
      chk("stall.txl_lat", 32'(log_q[base+1].cyc - log_q[base].cyc), 32'd5);
      chk("stall.txr_lat", 32'(log_q[base+2].cyc - log_q[base+1].cyc), 32'd2);
    end

    // ---- underrun: SR=0x15 while running ----
    base = log_q.size();
    sr_special = 32'h0000_0015;
    sr_target  = sr_done + 1;
    send_pair(32'hC1C1_C1C1, 32'hC2C2_C2C2);
    wait_log("urun.log", 3, 100);
    @(negedge clk);
    chk_tx("urun.txr", 2, 1'b1, c_BASE + 32'hC, 32'hC2C2_C2C2);
    chk("urun.flag", 32'(o_underrun), 32'h1);
    chk("urun.running", 32'(o_running), 32'h0);
    base = log_q.size();
    send_pair(32'hD1D1_D1D1, 32'hD2D2_D2D2);
    wait_log("urun.log2", 4, 100);
    @(negedge clk);
    chk_tx("urun.txl2", 1, 1'b1, c_BASE + 32'h8, 32'hD1D1_D1D1);
    chk_tx("urun.cr", 3, 1'b1, c_BASE, 32'h1);
    chk("urun.running2", 32'(o_running), 32'h1);
    chk("urun.sticky", 32'(o_underrun), 32'h1);
    chk("urun.cnt", 32'(o_pair_cnt), 32'd8);
    pulse_clear();
    chk("urun.clear", 32'(o_underrun), 32'h0);

    // ---- i_enable drops between TXL and TXR ----
    base = log_q.size();
    send_pair(32'hE1E1_E1E1, 32'hE2E2_E2E2);
    wait_access("stop.wait", c_BASE + 32'h8);
    i_enable = 1'b0;
    wait_log("stop.log", 4, 100);
    repeat (5) @(negedge clk);
    chk_tx("stop.txr", 2, 1'b1, c_BASE + 32'hC, 32'hE2E2_E2E2);
    chk_tx("stop.cr", 3, 1'b1, c_BASE, 32'h0);
    chk("stop.running", 32'(o_running), 32'h0);
    chk("stop.idle", {29'h0, s_ready, m_psel, m_penable}, 32'h0);
    chk("stop.nlog", 32'(log_q.size() - base), 32'd4);
    chk("stop.cnt", 32'(o_pair_cnt), 32'd9);

    // ---- pslverr on TXR ----
    base = log_q.size();
    i_enable = 1'b1;
    err_txr  = 1'b1;
    send_pair(32'hF1F1_F1F1, 32'hF2F2_F2F2);
    wait_log("perr.log", 4, 100);
    @(negedge clk);
    err_txr = 1'b0;
    chk_tx("perr.cr", 3, 1'b1, c_BASE, 32'h1);
    chk("perr.err", 32'(o_err), 32'h1);
    chk("perr.cnt", 32'(o_pair_cnt), 32'd10);
    chk("perr.running", 32'(o_running), 32'h1);
    pulse_clear();
    chk("perr.clear", 32'(o_err), 32'h0);

    // ---- asynchronous reset in the middle of an ACCESS phase ----
    hold_txl = 1'b1;
    send_pair(32'h1234_5678, 32'h9ABC_DEF0);
    wait_access("rst.wait", c_BASE + 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.apb", {30'h0, m_psel, m_penable}, 32'h0);
    chk("rst.paddr", m_paddr, 32'h0);
    chk("rst.pwdata", m_pwdata, 32'h0);
    chk("rst.flags", {27'h0, s_ready, m_pwrite, o_running, o_underrun, o_err}, 32'h0);
    chk("rst.cnt", 32'(o_pair_cnt), 32'h0);
    hold_txl = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_apb_feeder.md
Name: i2s_apb_feeder

Overview:
- APB master sequencer that streams stereo samples into the I2S transmitter's APB register file.
- Accepts left/right sample pairs on a valid/ready stream and polls the transmitter status register.
- Writes the TXL then TXR pseudo-registers, and pre-fills the FIFOs before setting CR.I2S_ENABLE.
- Detects underrun (auto switch-off of the transmitter) and restarts it after refilling. Sits between an audio source (DMA or generator) and the APB slave port of the I2S block.

Parameters:
- BASE_ADDR, 32'h0000_0000, APB base address of the I2S register block.
- PREFILL, 2, number of sample pairs written before CR.I2S_ENABLE is set (1..2^FIFO_DEPTH).
- POLL_GAP, 4, idle cycles between status polls while a FIFO is full (>=1).

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_enable, in, 1: level; 1 = run the stream, 0 = drain and stop.
- i_clear, in, 1: pulse; clears the sticky o_underrun and o_err flags.
- s_valid, in, 1: sample pair valid.
- s_left, in, 32: left-channel sample.
- s_right, in, 32: right-channel sample.
- s_ready, out, 1: sample pair accepted when s_valid & s_ready.
- m_paddr, out, 32: APB address.
- m_psel, out, 1: APB select.
- m_penable, out, 1: APB enable.
- m_pwrite, out, 1: APB write.
- m_pwdata, out, 32: APB write data.
- m_prdata, in, 32: APB read data.
- m_pready, in, 1: APB ready.
- m_pslverr, in, 1: APB error.
- o_running, out, 1: feeder's copy of CR.I2S_ENABLE.
- o_underrun, out, 1: sticky; transmitter ran dry while running.
- o_err, out, 1: sticky; a pslverr was seen.
- o_pair_cnt, out, 16: pairs written, wraps 0xFFFF->0.

Behaviour:
- Register offsets from BASE_ADDR: CR 0x00 (bit0 I2S_ENABLE), SR 0x04, TXL 0x08, TXR 0x0C.
- SR bits: [0] fifol_empty, [1] fifol_full, [2] fifor_empty, [3] fifor_full, [4] i2s_tx_done.
- Reset: all outputs 0; FSM in IDLE; hold registers and prefill counter 0.
- Every APB access takes a SETUP cycle (psel=1, penable=0), then ACCESS cycles (psel=1, penable=1) until pready.
  - paddr, pwrite and pwdata stay stable across SETUP and ACCESS.
  - prdata is sampled on the pready cycle.
  - A 0-wait access takes 2 cycles.
- FSM states: IDLE, FETCH, POLL_S, POLL_A, GAP, WRL_S, WRL_A, WRR_S, WRR_A, CR_S, CR_A.
- IDLE: if i_enable -> FETCH.
- FETCH: s_ready=1 (the only state with s_ready high).
  - On s_valid: latch s_left/s_right into hold registers -> POLL_S.
  - If i_enable=0 with no valid: if o_running -> CR_S (write 0), else -> IDLE.
- POLL_A, on pready: read SR.
  - If o_running and SR[4]=1: o_underrun<=1, o_running<=0, prefill counter<=0. The hardware has already cleared the enable.
  - Then if SR[1] or SR[3] -> GAP; else -> WRL_S.
- GAP: wait POLL_GAP cycles -> POLL_S.
- WRL (TXL, hold left) -> WRR (TXR, hold right).
  - An L/R pair is never split; i_enable falling mid-pair does not abort it.
- After WRR_A completes:
  - o_pair_cnt++; prefill counter++ (saturating at PREFILL).
  - If !o_running and prefill counter==PREFILL and i_enable -> CR_S (write 1).
  - Else -> FETCH.
- CR_A on pready: o_running <= written bit -> FETCH if written 1, IDLE if written 0.
- i_enable=0 while running: the current pair completes, then CR is written to 0 on the next FETCH.
- pslverr on any pready cycle: o_err<=1. The access is treated as complete and the sequence continues.
- i_clear: clears o_underrun/o_err the next cycle. If i_clear coincides with a new set event, the set wins.
- Reset mid-access: psel and penable drop to 0 asynchronously. The held sample is lost.

Test Plan:
- PREFILL=2, pready=1, SR=0, two pairs (L=0x11111111, R=0x22222222; L=0x33333333, R=0x44444444) -> APB sequence: RD 0x04, WR 0x08, WR 0x0C, RD 0x04, WR 0x08, WR 0x0C, WR 0x00=1. o_running=1, o_pair_cnt=2.
- SR returns 0x0A (both full) for 3 polls, then 0 -> 3 polls separated by POLL_GAP=4 idle cycles, then a TXL write. s_ready stays low throughout.
- pready held low 3 cycles on a TXL write -> psel, penable, paddr and pwdata held stable for 4 ACCESS cycles; the TXR write follows only after.
- While running, poll returns SR=0x15 -> o_underrun=1, o_running=0. Two more pairs are written, then CR=1 is rewritten. i_clear -> o_underrun=0.
- i_enable drops between the TXL and TXR writes -> TXR still written, then WR 0x00=0, o_running=0, FSM returns to IDLE.
- pslverr=1 on the TXR write -> o_err=1 and o_pair_cnt still increments. Asserting i_rst_n=0 mid-ACCESS -> all outputs 0 immediately.
